// File: rtl/start_pkg.sv
// Shared state encoding and width helpers for the start-light sequencer.
package start_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StLeds  = 3'd2,
    StDelay = 3'd3,
    StGo    = 3'd4,
    StFault = 3'd5
  } ty_STATE_START;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough for MIN_DELAY plus the largest i_prbs value.
  function automatic int unsigned dly_w(input int unsigned min_delay,
                                        input int unsigned delay_w);
    return $clog2(min_delay + (32'd1 << delay_w));
  endfunction

endpackage

// File: rtl/reaction_timer.sv
// Saturating reaction tick counter with capture register and one-cycle valid pulse.
module reaction_timer #(
  parameter int unsigned REACT_W = 12
) (
  input  logic               i_clk,
  input  logic               i_arstn,
  input  logic               i_clear,
  input  logic               i_count,
  input  logic               i_capture,
  output logic               o_sat,
  output logic [REACT_W-1:0] o_ticks,
  output logic               o_valid
);

  if (REACT_W < 2) begin : g_bad_react_w
    $error("REACT_W must be >= 2");
  end

  logic [REACT_W-1:0] cnt_q;
  logic [REACT_W-1:0] ticks_q;
  logic               valid_q;

  assign o_sat   = &cnt_q;
  assign o_ticks = ticks_q;
  assign o_valid = valid_q;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      cnt_q   <= '0;
      ticks_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= i_capture;
      if (i_capture) begin
        ticks_q <= cnt_q;
      end
      if (i_clear) begin
        cnt_q <= '0;
      end else if (i_count && !o_sat) begin
        cnt_q <= cnt_q + REACT_W'(1);
      end
    end
  end

endmodule

// File: rtl/start_sequencer.sv
// Starting-line controller: lights LEDs on ticks, waits a random delay, signals GO
// and times the player's reaction; early presses are flagged as false starts.
module start_sequencer
  import start_pkg::*;
#(
  parameter int unsigned N_LEDS     = 10,
  parameter int unsigned STEP_TICKS = 1,
  parameter int unsigned DELAY_W    = 8,
  parameter int unsigned MIN_DELAY  = 16,
  parameter int unsigned REACT_W    = 12
) (
  input  logic               i_clk,
  input  logic               i_arstn,
  input  logic               i_tick,
  input  logic               i_trigger,
  input  logic               i_react,
  input  logic [DELAY_W-1:0] i_prbs,
  output logic               o_rstPRBS,
  output logic               o_enPRBS,
  output logic [N_LEDS-1:0]  o_turnOnLED,
  output logic               o_go,
  output logic               o_falseStart,
  output logic [REACT_W-1:0] o_reactTicks,
  output logic               o_reactValid
);

  if (N_LEDS < 2) begin : g_bad_n_leds
    $error("N_LEDS must be >= 2");
  end
  if (STEP_TICKS < 1) begin : g_bad_step_ticks
    $error("STEP_TICKS must be >= 1");
  end
  if (DELAY_W < 1) begin : g_bad_delay_w
    $error("DELAY_W must be >= 1");
  end

  localparam int unsigned STEP_W = cnt_w(STEP_TICKS);
  localparam int unsigned DLY_W  = dly_w(MIN_DELAY, DELAY_W);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);

  ty_STATE_START     state_q, state_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              capture;
  logic              timer_sat;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q <= StIdle;
      leds_q  <= '0;
      step_q  <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      step_q  <= step_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    leds_d       = leds_q;
    step_d       = step_q;
    dly_d        = dly_q;
    capture      = 1'b0;
    o_rstPRBS    = 1'b0;
    o_enPRBS     = 1'b0;
    o_go         = 1'b0;
    o_falseStart = 1'b0;
    case (state_q)
      StIdle: begin
        o_rstPRBS = 1'b1;
        state_d   = StArmed;
      end
      StArmed: begin
        o_enPRBS = 1'b1;
        if (i_trigger) begin
          state_d = StLeds;
          dly_d   = DLY_W'(MIN_DELAY) + DLY_W'(i_prbs);
          leds_d  = '0;
          step_d  = '0;
        end
      end
      StLeds: begin
        // A press before GO wins over every other transition.
        if (i_react) begin
          state_d = StFault;
        end else if (&leds_q) begin
          state_d = StDelay;
        end else if (i_tick) begin
          if (step_q == STEP_LAST) begin
            leds_d = {leds_q[N_LEDS-2:0], 1'b1};
            step_d = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      StDelay: begin
        if (i_react) begin
          state_d = StFault;
        end else if (i_tick) begin
          if (dly_q == '0) begin
            state_d = StGo;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      StGo: begin
        o_go = 1'b1;
        if (i_react || (i_tick && timer_sat)) begin
          capture = 1'b1;
          state_d = StIdle;
        end
      end
      StFault: begin
        o_falseStart = 1'b1;
        if (i_trigger) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Lights are only ever shown while counting up or waiting for GO.
    if (state_d != StLeds && state_d != StDelay) begin
      leds_d = '0;
    end
  end

  assign o_turnOnLED = leds_q;

  reaction_timer #(
    .REACT_W(REACT_W)
  ) u_reaction_timer (
    .i_clk    (i_clk),
    .i_arstn  (i_arstn),
    .i_clear  (state_q != StGo),
    .i_count  (i_tick && (state_q == StGo)),
    .i_capture(capture),
    .o_sat    (timer_sat),
    .o_ticks  (o_reactTicks),
    .o_valid  (o_reactValid)
  );

endmodule
